// File: rtl/mixer_prims_pkg.sv
// Shared widths and constants for the mixer datapath primitives.
// Imported by ringbuf, pop_latch, mpemu_scale and the mixer_prims wrapper.
package mixer_prims_pkg;

  localparam int SAMPLE_WIDTH = 24;
  localparam int VOL_WIDTH    = 32;
  localparam int PROD_WIDTH   = 56;
  localparam int MULT_LATENCY = 6;
  localparam int RB_LEN       = 4;
  localparam int RB_LEN_LOG2  = 2;

  localparam logic [VOL_WIDTH-1:0] VOL_UNITY = 32'h0100_0000;

endpackage

// File: rtl/mixer_prims_units.sv
// Datapath primitives: ringbuf (4-deep sample ring), pop_latch (pending-pop
// flag) and mpemu_scale (6-stage signed sample*volume multiplier).
import mixer_prims_pkg::*;

// ringbuf: clk, rst, data_i/we_i write port, pop_i advances the read pointer,
// data_o = mem[rd_ptr + offset_i] (combinational). No full/empty guards.
module ringbuf #(
  parameter int LEN      = RB_LEN,
  parameter int LEN_LOG2 = RB_LEN_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] data_i,
  input  logic                    we_i,
  input  logic                    pop_i,
  input  logic [LEN_LOG2-1:0]     offset_i,
  output logic [SAMPLE_WIDTH-1:0] data_o
);

  logic [SAMPLE_WIDTH-1:0] mem [LEN];
  logic [LEN_LOG2-1:0]     wr_ptr;
  logic [LEN_LOG2-1:0]     rd_ptr;
  logic [LEN_LOG2-1:0]     rd_idx;

  // Pointers are exactly LEN_LOG2 wide, so natural overflow is mod LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < LEN; i++) mem[i] <= '0;
    end else begin
      if (we_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_i) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_idx = rd_ptr + offset_i;
  assign data_o = mem[rd_idx];

endmodule

// pop_latch: clk, rst, pop_i sets, ack_pop_i clears, pop_latched_o flag.
// A set in the same cycle as an ack wins so no request is dropped.
module pop_latch (
  input  logic clk,
  input  logic rst,
  input  logic pop_i,
  input  logic ack_pop_i,
  output logic pop_latched_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pop_latched_o <= 1'b0;
    else if (pop_i)     pop_latched_o <= 1'b1;
    else if (ack_pop_i) pop_latched_o <= 1'b0;
  end

endmodule

// mpemu_scale: clk, mpcand_i (signed sample), scale_i (signed Q8.24 volume),
// mprod_o full-width signed product, MULT_LATENCY cycles later. No reset.
module mpemu_scale (
  input  logic                  clk,
  input  logic [SAMPLE_WIDTH-1:0] mpcand_i,
  input  logic [VOL_WIDTH-1:0]    scale_i,
  output logic [PROD_WIDTH-1:0]   mprod_o
);

  logic signed [SAMPLE_WIDTH-1:0] delayed_a;
  logic signed [VOL_WIDTH-1:0]    delayed_b;
  logic signed [SAMPLE_WIDTH-1:0] delayed_a2;
  logic signed [VOL_WIDTH-1:0]    delayed_b2;
  logic signed [PROD_WIDTH-1:0]   prod;
  logic signed [PROD_WIDTH-1:0]   prod_d1;
  logic signed [PROD_WIDTH-1:0]   prod_d2;

  // Stage 1-2 operand regs, stage 3 multiply, stages 4-6 retiming delay.
  always_ff @(posedge clk) begin
    delayed_a  <= mpcand_i;
    delayed_b  <= scale_i;
    delayed_a2 <= delayed_a;
    delayed_b2 <= delayed_b;
    prod       <= delayed_a2 * delayed_b2;
    prod_d1    <= prod;
    prod_d2    <= prod_d1;
    mprod_o    <= prod_d2;
  end

endmodule

// File: rtl/mixer_prims.sv
// Wrapper exposing one ringbuf, one pop_latch and one mpemu_scale.
// Ports: rb_* ring buffer, pl_* pop latch, mp_* multiplier; clk, rst shared.
import mixer_prims_pkg::*;

module mixer_prims (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] rb_data_i,
  input  logic                    rb_we_i,
  input  logic                    rb_pop_i,
  input  logic [RB_LEN_LOG2-1:0]  rb_offset_i,
  output logic [SAMPLE_WIDTH-1:0] rb_data_o,
  input  logic                    pl_pop_i,
  input  logic                    pl_ack_pop_i,
  output logic                    pl_pop_latched_o,
  input  logic [SAMPLE_WIDTH-1:0] mp_mpcand_i,
  input  logic [VOL_WIDTH-1:0]    mp_scale_i,
  output logic [PROD_WIDTH-1:0]   mp_mprod_o
);

  ringbuf #(
    .LEN      (RB_LEN),
    .LEN_LOG2 (RB_LEN_LOG2)
  ) u_rb (
    .clk      (clk),
    .rst      (rst),
    .data_i   (rb_data_i),
    .we_i     (rb_we_i),
    .pop_i    (rb_pop_i),
    .offset_i (rb_offset_i),
    .data_o   (rb_data_o)
  );

  pop_latch u_pl (
    .clk           (clk),
    .rst           (rst),
    .pop_i         (pl_pop_i),
    .ack_pop_i     (pl_ack_pop_i),
    .pop_latched_o (pl_pop_latched_o)
  );

  mpemu_scale u_mp (
    .clk      (clk),
    .mpcand_i (mp_mpcand_i),
    .scale_i  (mp_scale_i),
    .mprod_o  (mp_mprod_o)
  );

endmodule

// File: tb/tb_mixer_prims.sv
// Bench for mixer_prims: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mixer_prims;

  logic        clk;
  logic        rst;
  logic [23:0] rb_data_i;
  logic        rb_we_i;
  logic        rb_pop_i;
  logic [1:0]  rb_offset_i;
  logic [23:0] rb_data_o;
  logic        pl_pop_i;
  logic        pl_ack_pop_i;
  logic        pl_pop_latched_o;
  logic [23:0] mp_mpcand_i;
  logic [31:0] mp_scale_i;
  logic [55:0] mp_mprod_o;

  int checks;
  int failures;

  mixer_prims dut (
    .clk              (clk),
    .rst              (rst),
    .rb_data_i        (rb_data_i),
    .rb_we_i          (rb_we_i),
    .rb_pop_i         (rb_pop_i),
    .rb_offset_i      (rb_offset_i),
    .rb_data_o        (rb_data_o),
    .pl_pop_i         (pl_pop_i),
    .pl_ack_pop_i     (pl_ack_pop_i),
    .pl_pop_latched_o (pl_pop_latched_o),
    .mp_mpcand_i      (mp_mpcand_i),
    .mp_scale_i       (mp_scale_i),
    .mp_mprod_o       (mp_mprod_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [23:0] m_mem [4];
  int          m_wp;
  int          m_rp;
  logic        m_lat;
  logic [55:0] m_q [$];

  initial begin
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_wp = 0; m_rp = 0; m_lat = 1'b0;
  end

  always @(posedge clk) begin
    longint p;
    logic [55:0] exp_p;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      m_wp = 0;
      m_rp = 0;
      m_lat = 1'b0;
      m_q.delete();
    end else begin
      if (rb_we_i) begin
        m_mem[m_wp] = rb_data_i;
        m_wp = (m_wp + 1) % 4;
      end
      if (rb_pop_i) m_rp = (m_rp + 1) % 4;
      if (pl_pop_i) m_lat = 1'b1;
      else if (pl_ack_pop_i) m_lat = 1'b0;
      p = longint'($signed(mp_mpcand_i)) * longint'($signed(mp_scale_i));
      exp_p = p[55:0];
      m_q.push_back(exp_p);
    end
    #1;
    check("rb_data", {40'd0, rb_data_o}, {40'd0, m_mem[(m_rp + int'(rb_offset_i)) % 4]});
    check("pl_latched", {63'd0, pl_pop_latched_o}, {63'd0, m_lat});
    if (m_q.size() == 6) begin
      check("mp_prod", {8'd0, mp_mprod_o}, {8'd0, m_q[0]});
      void'(m_q.pop_front());
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rb_data_i = '0; rb_we_i = 0; rb_pop_i = 0; rb_offset_i = '0;
    pl_pop_i = 0; pl_ack_pop_i = 0;
    mp_mpcand_i = '0; mp_scale_i = '0;
    repeat (2) @(negedge clk);
    check("rst_rb", {40'd0, rb_data_o}, 64'd0);
    check("rst_pl", {63'd0, pl_pop_latched_o}, 64'd0);
    rst = 1'b0;

    // ring buffer basic + wrap
    for (int i = 1; i <= 3; i++) begin
      rb_data_i = 24'(i); rb_we_i = 1;
      @(negedge clk);
    end
    rb_we_i = 0; rb_offset_i = 2'd0;
    #1 check("rb_off0", {40'd0, rb_data_o}, 64'h1);
    rb_offset_i = 2'd2;
    #1 check("rb_off2", {40'd0, rb_data_o}, 64'h3);
    rb_offset_i = 2'd0; rb_pop_i = 1;
    @(negedge clk);
    rb_pop_i = 0;
    #1 check("rb_pop1", {40'd0, rb_data_o}, 64'h2);
    rb_pop_i = 1;
    repeat (3) @(negedge clk);
    rb_pop_i = 0;
    #1 check("rb_wrap", {40'd0, rb_data_o}, 64'h1);

    // overflow
    rst = 1; @(negedge clk); rst = 0;
    for (int i = 1; i <= 5; i++) begin
      rb_data_i = 24'(i); rb_we_i = 1;
      @(negedge clk);
    end
    rb_we_i = 0;
    #1 check("rb_ovf", {40'd0, rb_data_o}, 64'h5);

    // simultaneous write + pop
    rst = 1; @(negedge clk); rst = 0;
    rb_we_i = 1; rb_data_i = 24'd10; rb_pop_i = 0;
    @(negedge clk);
    rb_data_i = 24'd11; rb_pop_i = 1;
    @(negedge clk);
    rb_data_i = 24'd12;
    @(negedge clk);
    rb_we_i = 0; rb_pop_i = 0;
    #1 check("rb_wepop", {40'd0, rb_data_o}, 64'd12);

    // pop latch
    pl_pop_i = 1; @(negedge clk); pl_pop_i = 0;
    check("pl_set", {63'd0, pl_pop_latched_o}, 64'd1);
    @(negedge clk);
    check("pl_hold", {63'd0, pl_pop_latched_o}, 64'd1);
    pl_ack_pop_i = 1; @(negedge clk); pl_ack_pop_i = 0;
    check("pl_ack", {63'd0, pl_pop_latched_o}, 64'd0);
    pl_pop_i = 1; pl_ack_pop_i = 1; @(negedge clk);
    pl_pop_i = 0; pl_ack_pop_i = 0;
    check("pl_setwins", {63'd0, pl_pop_latched_o}, 64'd1);
    @(posedge clk);
    #3 rst = 1;
    #1 check("pl_async", {63'd0, pl_pop_latched_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // multiplier
    mp_mpcand_i = 24'h100000; mp_scale_i = 32'h0100_0000;
    @(negedge clk);
    mp_mpcand_i = 24'hFFFFFF;
    @(negedge clk);
    mp_mpcand_i = 24'h800000; mp_scale_i = 32'h8000_0000;
    @(negedge clk);
    mp_mpcand_i = '0; mp_scale_i = '0;
    repeat (3) @(negedge clk);
    check("mp_pos", {8'd0, mp_mprod_o}, 64'h0000_1000_0000_0000);
    @(negedge clk);
    check("mp_neg", {8'd0, mp_mprod_o}, 64'h00FF_FFFF_FF00_0000);
    @(negedge clk);
    check("mp_ext", {8'd0, mp_mprod_o}, 64'h0040_0000_0000_0000);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst          = ($urandom_range(0, 96) == 0);
      rb_data_i    = 24'($urandom);
      rb_we_i      = 1'($urandom);
      rb_pop_i     = 1'($urandom);
      rb_offset_i  = 2'($urandom);
      pl_pop_i     = ($urandom_range(0, 3) == 0);
      pl_ack_pop_i = ($urandom_range(0, 2) == 0);
      mp_mpcand_i  = 24'($urandom);
      mp_scale_i   = $urandom;
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
